// File: rtl/cheriot_tsmap_pkg.sv
// Shared types and helpers for the TS map (revocation bitmap) SRAM arbiter.
package cheriot_tsmap_pkg;

  localparam int unsigned TSMAP_WORD_BYTES = 4;
  localparam int unsigned TSMAP_ADDR_W     = 16;

  typedef struct packed {
    logic                          we;
    logic [TSMAP_WORD_BYTES-1:0]   be;
    logic [TSMAP_ADDR_W-1:0]       addr;
    logic [8*TSMAP_WORD_BYTES-1:0] wdata;
  } tsmap_req_t;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_CORE,
    OWN_BUS
  } tsmap_owner_e;

  function automatic logic tsmap_in_range(input logic [31:0] addr, input int unsigned size);
    return addr < 32'(size);
  endfunction

endpackage

// File: rtl/cheriot_tsmap_starve_ctr.sv
// Saturating bus-stall counter with sticky starvation flag and optional one-cycle core hold.
// Optional fairness hold enabled by CHERIOT_TSMAP_ARB_FAIRNESS_EN.
module cheriot_tsmap_starve_ctr #(
  parameter int unsigned StallLimit = 8
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic bus_req_i,
  input  logic bus_gnt_i,
  output logic starve_o,
  output logic hold_o
);

  localparam logic [7:0] Limit = 8'(StallLimit);

  logic [7:0] cnt_q, cnt_d;
  logic       starve_q;
  logic       hit;

  // hit marks the single edge where the count first reaches the limit
  always_comb begin
    cnt_d = cnt_q;
    hit   = 1'b0;
    if (!bus_req_i || bus_gnt_i) begin
      cnt_d = '0;
    end else if (cnt_q < Limit) begin
      cnt_d = cnt_q + 8'd1;
      hit   = (cnt_d == Limit);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q    <= '0;
      starve_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      if (bus_gnt_i) begin
        starve_q <= 1'b0;
      end else if (hit) begin
        starve_q <= 1'b1;
      end
    end
  end

  assign starve_o = starve_q;

`ifdef CHERIOT_TSMAP_ARB_FAIRNESS_EN
  logic hold_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hold_q <= 1'b0;
    end else begin
      hold_q <= hit;
    end
  end

  assign hold_o = hold_q;
`else
  assign hold_o = 1'b0;
`endif

endmodule

// File: rtl/cheriot_tsmap_arb.sv
// Single-port TS map SRAM arbiter: core read port by fixed priority, bus port in idle slots.
// Optional fairness hold enabled by CHERIOT_TSMAP_ARB_FAIRNESS_EN.
module cheriot_tsmap_arb
  import cheriot_tsmap_pkg::*;
#(
  parameter int unsigned TSMapSize  = 1024,
  parameter int unsigned AddrW      = 16,
  parameter int unsigned StallLimit = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             core_cs_i,
  input  logic [AddrW-1:0] core_addr_i,
  output logic [31:0]      core_rdata_o,
  output logic             core_hold_o,
  input  logic             bus_req_i,
  input  logic             bus_we_i,
  input  logic [3:0]       bus_be_i,
  input  logic [AddrW-1:0] bus_addr_i,
  input  logic [31:0]      bus_wdata_i,
  output logic             bus_gnt_o,
  output logic             bus_rvalid_o,
  output logic [31:0]      bus_rdata_o,
  output logic             bus_err_o,
  output logic             starve_o,
  output logic             mem_cs_o,
  output logic             mem_we_o,
  output logic [3:0]       mem_be_o,
  output logic [AddrW-1:0] mem_addr_o,
  output logic [31:0]      mem_wdata_o,
  input  logic [31:0]      mem_rdata_i
);

  tsmap_req_t   bus_req;
  tsmap_owner_e owner;
  logic         hold;
  logic         bus_in_range;
  logic         rvalid_q, err_q, rd_q;

  always_comb begin
    bus_req.we    = bus_we_i;
    bus_req.be    = bus_be_i;
    bus_req.addr  = TSMAP_ADDR_W'(bus_addr_i);
    bus_req.wdata = bus_wdata_i;
  end

  assign bus_in_range = tsmap_in_range(32'(bus_addr_i), TSMapSize);

  always_comb begin
    owner = OWN_NONE;
    if (core_cs_i && !hold) begin
      owner = OWN_CORE;
    end else if (bus_req_i) begin
      owner = OWN_BUS;
    end
  end

  assign bus_gnt_o = (owner == OWN_BUS);

  always_comb begin
    mem_cs_o    = 1'b0;
    mem_we_o    = 1'b0;
    mem_be_o    = '0;
    mem_addr_o  = core_addr_i;
    mem_wdata_o = bus_req.wdata;
    case (owner)
      OWN_CORE: begin
        mem_cs_o = 1'b1;
        mem_be_o = '1;
      end
      OWN_BUS: begin
        if (bus_in_range) begin
          mem_cs_o   = 1'b1;
          mem_we_o   = bus_req.we;
          mem_be_o   = bus_req.be;
          mem_addr_o = AddrW'(bus_req.addr);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      rd_q     <= 1'b0;
    end else begin
      rvalid_q <= bus_gnt_o;
      err_q    <= bus_gnt_o & ~bus_in_range;
      rd_q     <= bus_gnt_o & bus_in_range & ~bus_we_i;
    end
  end

  // Response is masked while reset is asserted so an access granted just before reset never completes
  assign bus_rvalid_o = rvalid_q & ~rst_i;
  assign bus_err_o    = err_q & ~rst_i;
  assign bus_rdata_o  = (rd_q & ~rst_i) ? mem_rdata_i : '0;
  assign core_rdata_o = mem_rdata_i;
  assign core_hold_o  = hold;

  cheriot_tsmap_starve_ctr #(
    .StallLimit(StallLimit)
  ) u_starve (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .bus_req_i(bus_req_i),
    .bus_gnt_i(bus_gnt_o),
    .starve_o (starve_o),
    .hold_o   (hold)
  );

`ifndef SYNTHESIS
  a_no_core_during_hold: assert property (@(posedge clk_i) disable iff (rst_i)
    !(core_cs_i && core_hold_o))
    else $error("core_cs_i asserted while core_hold_o is high");
`endif

endmodule

// File: tb/tb_cheriot_tsmap_arb.sv
// Bench for cheriot_tsmap_arb: directed test-plan steps plus randomized traffic against a transaction-level model.
module tb_cheriot_tsmap_arb;

  localparam int SIZE  = 1024;
  localparam int LIMIT = 8;
`ifdef CHERIOT_TSMAP_ARB_FAIRNESS_EN
  localparam bit FAIR = 1'b1;
`else
  localparam bit FAIR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_i;
  logic        core_cs_i;
  logic [15:0] core_addr_i;
  logic [31:0] core_rdata_o;
  logic        core_hold_o;
  logic        bus_req_i, bus_we_i;
  logic [3:0]  bus_be_i;
  logic [15:0] bus_addr_i;
  logic [31:0] bus_wdata_i;
  logic        bus_gnt_o, bus_rvalid_o, bus_err_o, starve_o;
  logic [31:0] bus_rdata_o;
  logic        mem_cs_o, mem_we_o;
  logic [3:0]  mem_be_o;
  logic [15:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [31:0] mem_rdata_i;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cheriot_tsmap_arb #(.TSMapSize(SIZE), .AddrW(16), .StallLimit(LIMIT)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .core_cs_i(core_cs_i), .core_addr_i(core_addr_i), .core_rdata_o(core_rdata_o),
    .core_hold_o(core_hold_o),
    .bus_req_i(bus_req_i), .bus_we_i(bus_we_i), .bus_be_i(bus_be_i), .bus_addr_i(bus_addr_i),
    .bus_wdata_i(bus_wdata_i), .bus_gnt_o(bus_gnt_o), .bus_rvalid_o(bus_rvalid_o),
    .bus_rdata_o(bus_rdata_o), .bus_err_o(bus_err_o), .starve_o(starve_o),
    .mem_cs_o(mem_cs_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i)
  );

  function automatic logic [31:0] init_word(input int i);
    if (i == 16) return 32'hDEADBEEF;
    return (32'(i) * 32'h9E3779B9) ^ 32'hA5A50000;
  endfunction

  // SRAM behavioural model, one-cycle read latency; reloaded on every reset edge
  logic [31:0] sram [SIZE];
  logic [31:0] sram_rdata = '0;
  assign mem_rdata_i = sram_rdata;

  always @(posedge clk) begin
    if (rst_i) begin
      for (int i = 0; i < SIZE; i++) sram[i] <= init_word(i);
    end else if (mem_cs_o) begin
      if (mem_we_o) begin
        for (int b = 0; b < 4; b++)
          if (mem_be_o[b]) sram[mem_addr_o[9:0]][8*b +: 8] <= mem_wdata_o[8*b +: 8];
      end else begin
        sram_rdata <= sram[mem_addr_o[9:0]];
      end
    end
  end

  // Transaction-level reference state
  logic [31:0] ref_mem [SIZE];
  int          denied;
  logic        starve_exp, hold_exp;
  logic        exp_rvalid, exp_err, exp_core_valid;
  logic [31:0] exp_rdata, exp_core_rdata;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
  endtask

  task automatic model_reset();
    for (int i = 0; i < SIZE; i++) ref_mem[i] = init_word(i);
    denied = 0; starve_exp = 1'b0; hold_exp = 1'b0;
    exp_rvalid = 1'b0; exp_err = 1'b0; exp_rdata = '0;
    exp_core_valid = 1'b0; exp_core_rdata = '0;
  endtask

  task automatic do_reset();
    #1;
    rst_i = 1'b1; core_cs_i = 1'b0; bus_req_i = 1'b0;
    #1;
    chk("rst_rvalid", 32'(bus_rvalid_o), 0);
    chk("rst_err", 32'(bus_err_o), 0);
    @(posedge clk);
    model_reset();
  endtask

  // One clock cycle: drive, check against the model, advance the model across the edge
  task automatic cycle(input logic c_cs, input logic [15:0] c_addr, input logic b_req,
                       input logic b_we, input logic [3:0] b_be, input logic [15:0] b_addr,
                       input logic [31:0] b_wdata, output logic g);
    logic core_own, in_r, reached;
    #1;
    rst_i = 1'b0;
    core_cs_i   = hold_exp ? 1'b0 : c_cs;
    core_addr_i = c_addr;
    bus_req_i = b_req; bus_we_i = b_we; bus_be_i = b_be;
    bus_addr_i = b_addr; bus_wdata_i = b_wdata;
    core_own = core_cs_i;
    g    = b_req && !core_own;
    in_r = (int'(b_addr) < SIZE);
    #1;
    chk("gnt", 32'(bus_gnt_o), 32'(g));
    chk("hold", 32'(core_hold_o), 32'(hold_exp));
    chk("starve", 32'(starve_o), 32'(starve_exp));
    chk("mem_cs", 32'(mem_cs_o), 32'(core_own || (g && in_r)));
    if (core_own) begin
      chk("core_mem_addr", 32'(mem_addr_o), 32'(c_addr));
      chk("core_mem_we", 32'(mem_we_o), 0);
      chk("core_mem_be", 32'(mem_be_o), 32'hF);
    end else if (g && in_r) begin
      chk("bus_mem_addr", 32'(mem_addr_o), 32'(b_addr));
      chk("bus_mem_we", 32'(mem_we_o), 32'(b_we));
      if (b_we) begin
        chk("bus_mem_be", 32'(mem_be_o), 32'(b_be));
        chk("bus_mem_wdata", mem_wdata_o, b_wdata);
      end
    end
    chk("rvalid", 32'(bus_rvalid_o), 32'(exp_rvalid));
    if (exp_rvalid) begin
      chk("err", 32'(bus_err_o), 32'(exp_err));
      chk("rdata", bus_rdata_o, exp_rdata);
    end
    if (exp_core_valid) chk("core_rdata", core_rdata_o, exp_core_rdata);

    exp_core_valid = core_own;
    exp_core_rdata = ref_mem[c_addr[9:0]];
    exp_rvalid = g;
    exp_err    = g && !in_r;
    exp_rdata  = (g && in_r && !b_we) ? ref_mem[b_addr[9:0]] : '0;
    if (g && in_r && b_we)
      for (int b = 0; b < 4; b++)
        if (b_be[b]) ref_mem[b_addr[9:0]][8*b +: 8] = b_wdata[8*b +: 8];
    reached = 1'b0;
    if (!b_req || g) denied = 0;
    else if (denied < LIMIT) begin
      denied++;
      reached = (denied == LIMIT);
    end
    if (g) starve_exp = 1'b0;
    else if (reached) starve_exp = 1'b1;
    hold_exp = FAIR && reached;
    @(posedge clk);
  endtask

  initial begin
    logic        g, granted, pend, p_we;
    logic [3:0]  p_be;
    logic [15:0] p_addr;
    logic [31:0] p_wdata, old_word;
    int          first_gnt;

    rst_i = 1'b1; core_cs_i = 1'b0; core_addr_i = '0; bus_req_i = 1'b0; bus_we_i = 1'b0;
    bus_be_i = '0; bus_addr_i = '0; bus_wdata_i = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_rvalid", 32'(bus_rvalid_o), 0);
    chk("reset_err", 32'(bus_err_o), 0);
    chk("reset_starve", 32'(starve_o), 0);
    chk("reset_hold", 32'(core_hold_o), 0);
    model_reset();

    // Bus read of word 0x10 with the core idle
    cycle(1'b0, 16'h0, 1'b1, 1'b0, 4'hF, 16'h0010, '0, g);
    #2;
    chk("tp_read_rvalid", 32'(bus_rvalid_o), 1);
    chk("tp_read_rdata", bus_rdata_o, 32'hDEADBEEF);
    chk("tp_read_err", 32'(bus_err_o), 0);

    // Partial bus write then core read of the same word
    old_word = ref_mem[32];
    cycle(1'b0, 16'h0, 1'b1, 1'b1, 4'b0011, 16'h0020, 32'h12345678, g);
    cycle(1'b1, 16'h0020, 1'b0, 1'b0, 4'h0, 16'h0, '0, g);
    cycle(1'b0, 16'h0, 1'b0, 1'b0, 4'h0, 16'h0, '0, g);
    #2;
    chk("tp_wr_low", 32'(core_rdata_o[15:0]), 32'h5678);
    chk("tp_wr_high", 32'(core_rdata_o[31:16]), 32'(old_word[31:16]));

    // Out-of-range bus read
    cycle(1'b0, 16'h0, 1'b1, 1'b0, 4'hF, 16'd1024, '0, g);
    #2;
    chk("tp_oor_err", 32'(bus_err_o), 1);
    chk("tp_oor_rdata", bus_rdata_o, 0);

    // Core busy for 20 cycles with a bus read pending
    granted = 1'b0; first_gnt = 0;
    for (int i = 1; i <= 20; i++) begin
      cycle(1'b1, 16'($urandom_range(0, SIZE-1)), !granted, 1'b0, 4'hF, 16'h0040, '0, g);
      if (g && !granted) begin granted = 1'b1; first_gnt = i; end
    end
    if (!granted) begin
      cycle(1'b0, 16'h0, 1'b1, 1'b0, 4'hF, 16'h0040, '0, g);
      if (g) first_gnt = 21;
    end
    chk("tp_first_gnt", 32'(first_gnt), FAIR ? 32'd9 : 32'd21);
    cycle(1'b0, 16'h0, 1'b0, 1'b0, 4'h0, 16'h0, '0, g);
    #2;
    chk("tp_starve_cleared", 32'(starve_o), 0);

    // Reset in the cycle after a grant: no response, then a clean reissue
    cycle(1'b0, 16'h0, 1'b1, 1'b0, 4'hF, 16'h0055, '0, g);
    do_reset();
    chk("tp_rst_starve", 32'(starve_o), 0);
    cycle(1'b0, 16'h0, 1'b1, 1'b0, 4'hF, 16'h0055, '0, g);
    cycle(1'b0, 16'h0, 1'b0, 1'b0, 4'h0, 16'h0, '0, g);

    // Randomized traffic; a bus request stays up with fixed fields until granted
    pend = 1'b0; p_we = 1'b0; p_be = '0; p_addr = '0; p_wdata = '0;
    for (int n = 0; n < 400; n++) begin
      if (!pend && ($urandom_range(0, 1) == 1)) begin
        pend    = 1'b1;
        p_we    = 1'($urandom_range(0, 1));
        p_be    = 4'($urandom_range(0, 15));
        p_addr  = ($urandom_range(0, 7) == 0) ? 16'($urandom_range(SIZE, 65535))
                                              : 16'($urandom_range(0, SIZE-1));
        p_wdata = $urandom;
      end
      cycle(($urandom_range(0, 99) < 70), 16'($urandom_range(0, SIZE-1)),
            pend, p_we, p_be, p_addr, p_wdata, g);
      if (g) pend = 1'b0;
    end
    cycle(1'b0, 16'h0, 1'b0, 1'b0, 4'h0, 16'h0, '0, g);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
